// File: rtl/ysyx_25040129_axi4_master.sv
// AXI4 initiator with one transaction in flight: INCR read bursts or single-beat writes.
// A zero-wait slave gives the first response 3 cycles after the request; there is no response backpressure.
module ysyx_25040129_axi4_master #(
  parameter logic [3:0] AXI_ID    = 4'h0,
  parameter logic [7:0] BURST_MAX = 8'd3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic        io_master_awvalid,
  input  logic        io_master_awready,
  output logic [3:0]  io_master_awid,
  output logic [31:0] io_master_awaddr,
  output logic [7:0]  io_master_awlen,
  output logic [2:0]  io_master_awsize,
  output logic [1:0]  io_master_awburst,
  output logic        io_master_wvalid,
  input  logic        io_master_wready,
  output logic [31:0] io_master_wdata,
  output logic [3:0]  io_master_wstrb,
  output logic        io_master_wlast,
  input  logic        io_master_bvalid,
  output logic        io_master_bready,
  input  logic [3:0]  io_master_bid,
  input  logic [1:0]  io_master_bresp,
  output logic        io_master_arvalid,
  input  logic        io_master_arready,
  output logic [3:0]  io_master_arid,
  output logic [31:0] io_master_araddr,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  input  logic        io_master_rvalid,
  output logic        io_master_rready,
  input  logic [3:0]  io_master_rid,
  input  logic [31:0] io_master_rdata,
  input  logic [1:0]  io_master_rresp,
  input  logic        io_master_rlast
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, ERR} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_t     state, state_nxt;
  req_t       req_q;
  logic [7:0] cnt_q;
  logic       aw_done, w_done;
  logic       req_fire, ar_fire, r_fire, aw_fire, w_fire, b_fire, last_beat;
  logic       unused_ids;

  // Response ids are accepted whatever their value.
  assign unused_ids = ^{io_master_bid, io_master_rid};

  assign req_fire  = req_valid & req_ready;
  assign ar_fire   = io_master_arvalid & io_master_arready;
  assign r_fire    = io_master_rvalid & io_master_rready;
  assign aw_fire   = io_master_awvalid & io_master_awready;
  assign w_fire    = io_master_wvalid & io_master_wready;
  assign b_fire    = io_master_bvalid & io_master_bready;
  assign last_beat = (cnt_q == req_q.len);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_fire) begin
          if (req_we)                 state_nxt = WR;
          else if (req_len > BURST_MAX) state_nxt = ERR;
          else                        state_nxt = RD_ADDR;
        end
      end
      RD_ADDR: if (ar_fire) state_nxt = RD_DATA;
      // The beat count, not rlast, decides where the burst ends.
      RD_DATA: if (r_fire && last_beat) state_nxt = IDLE;
      WR:      if ((aw_done | aw_fire) && (w_done | w_fire)) state_nxt = WR_RESP;
      WR_RESP: if (b_fire) state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready         = (state == IDLE);
    io_master_arvalid = (state == RD_ADDR);
    io_master_rready  = (state == RD_DATA);
    io_master_awvalid = (state == WR) && !aw_done;
    io_master_wvalid  = (state == WR) && !w_done;
    io_master_bready  = (state == WR_RESP);
    io_master_awaddr  = req_q.addr;
    io_master_araddr  = req_q.addr;
    io_master_arlen   = req_q.len;
    io_master_awlen   = 8'd0;
    io_master_wdata   = req_q.wdata;
    io_master_wstrb   = req_q.wstrb;
    io_master_wlast   = io_master_wvalid;
    // Fixed attributes are only driven alongside their valid so idle outputs sit at zero.
    io_master_awid    = io_master_awvalid ? AXI_ID  : 4'h0;
    io_master_awsize  = io_master_awvalid ? 3'b010  : 3'b000;
    io_master_awburst = io_master_awvalid ? 2'b01   : 2'b00;
    io_master_arid    = io_master_arvalid ? AXI_ID  : 4'h0;
    io_master_arsize  = io_master_arvalid ? 3'b010  : 3'b000;
    io_master_arburst = io_master_arvalid ? 2'b01   : 2'b00;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_q     <= '0;
      cnt_q     <= 8'd0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
      if (req_fire) begin
        req_q   <= '{addr: req_addr, len: req_len, wdata: req_wdata, wstrb: req_wstrb};
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      case (state)
        RD_ADDR: if (ar_fire) cnt_q <= 8'd0;
        RD_DATA: begin
          if (r_fire) begin
            rsp_valid <= 1'b1;
            rsp_data  <= io_master_rdata;
            rsp_last  <= last_beat;
            rsp_err   <= (io_master_rresp != 2'b00) | (io_master_rlast != last_beat);
            cnt_q     <= cnt_q + 8'd1;
          end
        end
        WR: begin
          if (aw_fire) aw_done <= 1'b1;
          if (w_fire)  w_done  <= 1'b1;
        end
        WR_RESP: begin
          if (b_fire) begin
            rsp_valid <= 1'b1;
            rsp_data  <= 32'd0;
            rsp_last  <= 1'b1;
            rsp_err   <= (io_master_bresp != 2'b00);
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
          end
        end
        ERR: begin
          rsp_valid <= 1'b1;
          rsp_data  <= 32'd0;
          rsp_last  <= 1'b1;
          rsp_err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
